// File: rtl/normalizer_frame_ctrl.sv
// Per-frame sequencer: scans raw frame RAM for signed min/max, loads min/range into
// the normalizer, starts it, counts its pixel writes and flags done/timeout/dropped frames.
module normalizer_frame_ctrl #(
    parameter int unsigned DATAW          = 16,
    parameter int unsigned MAX_ADDR       = 767,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned ADDRW         = $clog2(MAX_ADDR + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_ready,
    output logic             o_scan_rd_valid,
    output logic [ADDRW-1:0] o_scan_rd_addr,
    input  logic [DATAW-1:0] i_scan_rd_data,
    output logic             o_norm_start,
    output logic [DATAW-1:0] o_norm_min,
    output logic [DATAW-1:0] o_norm_range,
    input  logic             i_norm_wr_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic             o_frame_dropped
);

    localparam int unsigned CNTW = $clog2(MAX_ADDR + 2);
    localparam int unsigned TOW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLUSH,
        CALC,
        START,
        WAIT_NORM,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [RD_LATENCY-1:0]    ret_pipe;
    logic                     ret_valid;
    logic                     seen;
    logic signed [DATAW-1:0]  min_q;
    logic signed [DATAW-1:0]  max_q;
    logic [DATAW-1:0]         range_c;
    logic [CNTW-1:0]          beat_cnt;
    logic [CNTW-1:0]          beat_nxt;
    logic [TOW-1:0]           cyc_cnt;
    logic                     complete_c;
    logic                     timeout_c;

    assign ret_valid  = ret_pipe[RD_LATENCY-1];
    assign beat_nxt   = beat_cnt + CNTW'(i_norm_wr_valid);
    assign complete_c = (state == WAIT_NORM) && (beat_nxt == CNTW'(MAX_ADDR + 1));
    assign timeout_c  = (state == WAIT_NORM) && !complete_c
                        && (cyc_cnt == TOW'(TIMEOUT_CYCLES - 1));
    // Range is formed one bit wider so that max-min of any signed pair fits unsigned.
    assign range_c    = DATAW'({max_q[DATAW-1], max_q} - {min_q[DATAW-1], min_q});

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (i_frame_ready) state_n = SCAN;
            SCAN:      if (o_scan_rd_addr == ADDRW'(MAX_ADDR)) state_n = FLUSH;
            FLUSH:     if (ret_pipe == '0) state_n = CALC;
            CALC:      state_n = START;
            START:     state_n = WAIT_NORM;
            WAIT_NORM: begin
                if (complete_c) begin
                    state_n = DONE;
                end else if (timeout_c) begin
                    state_n = IDLE;
                end
            end
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Registered outputs, scan datapath and normalizer beat/cycle counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_scan_rd_valid <= 1'b0;
            o_scan_rd_addr  <= '0;
            o_norm_start    <= 1'b0;
            o_norm_min      <= '0;
            o_norm_range    <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
            o_frame_dropped <= 1'b0;
            ret_pipe        <= '0;
            seen            <= 1'b0;
            min_q           <= '0;
            max_q           <= '0;
            beat_cnt        <= '0;
            cyc_cnt         <= '0;
        end else begin
            o_scan_rd_valid <= (state_n == SCAN);
            o_scan_rd_addr  <= ((state == SCAN) && (state_n == SCAN))
                               ? o_scan_rd_addr + ADDRW'(1) : '0;
            o_norm_start    <= (state_n == START);
            o_busy          <= (state_n != IDLE);
            o_done          <= (state_n == DONE);
            o_error         <= timeout_c;
            o_frame_dropped <= i_frame_ready && (state != IDLE);
            ret_pipe        <= RD_LATENCY'({ret_pipe, o_scan_rd_valid});

            if ((state == IDLE) && (state_n == SCAN)) begin
                seen <= 1'b0;
            end else if (ret_valid) begin
                seen <= 1'b1;
                if (!seen) begin
                    min_q <= i_scan_rd_data;
                    max_q <= i_scan_rd_data;
                end else begin
                    if ($signed(i_scan_rd_data) < min_q) min_q <= i_scan_rd_data;
                    if ($signed(i_scan_rd_data) > max_q) max_q <= i_scan_rd_data;
                end
            end

            if (state == CALC) begin
                o_norm_min   <= min_q;
                o_norm_range <= range_c;
            end

            if ((state == WAIT_NORM) && (state_n == WAIT_NORM)) begin
                beat_cnt <= beat_nxt;
                cyc_cnt  <= cyc_cnt + TOW'(1);
            end else begin
                beat_cnt <= '0;
                cyc_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_normalizer_frame_ctrl.sv
// Directed self-checking bench for normalizer_frame_ctrl with a 1-cycle frame RAM model.
module tb_normalizer_frame_ctrl;

    localparam int unsigned NPIX    = 768;
    localparam int          LAT_EXP = 768 + 1 + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_ready = 1'b0;
    logic        norm_wr_valid = 1'b0;
    logic        scan_rd_valid;
    logic [9:0]  scan_rd_addr;
    logic [15:0] ram_q = '0;
    logic        norm_start;
    logic [15:0] norm_min;
    logic [15:0] norm_range;
    logic        busy;
    logic        done;
    logic        error;
    logic        frame_dropped;

    logic [15:0] mem [0:NPIX-1];

    int checks = 0;
    int errors = 0;
    int exp_addr = 0;
    int nvalid = 0;
    int addr_bad = 0;

    normalizer_frame_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_frame_ready   (frame_ready),
        .o_scan_rd_valid (scan_rd_valid),
        .o_scan_rd_addr  (scan_rd_addr),
        .i_scan_rd_data  (ram_q),
        .o_norm_start    (norm_start),
        .o_norm_min      (norm_min),
        .o_norm_range    (norm_range),
        .i_norm_wr_valid (norm_wr_valid),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_frame_dropped (frame_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (scan_rd_valid) ram_q <= mem[scan_rd_addr];
    end

    // Scan address tracker: expects 0,1,2,... on consecutive valid cycles
    always @(negedge clk) begin
        if (!busy && !scan_rd_valid) begin
            exp_addr = 0;
            nvalid   = 0;
            addr_bad = 0;
        end else if (scan_rd_valid) begin
            if (scan_rd_addr !== 10'(exp_addr)) addr_bad++;
            exp_addr++;
            nvalid++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < NPIX; i++) mem[i] = v;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) mem[i] = 16'(-100 + i);
    endtask

    task automatic run_scan(input int drop_at, output int lat, output logic dropped);
        dropped = 1'b0;
        @(negedge clk);
        frame_ready = 1'b1;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == drop_at + 1) dropped = frame_dropped;
            frame_ready = (lat == drop_at);
            if (norm_start) break;
        end
        frame_ready = 1'b0;
    endtask

    task automatic finish_frame(input int beats, input logic extra, input logic drop_done,
                                output int j, output logic start_j1, output logic got_done,
                                output logic got_err, output logic busy_at,
                                output logic busy_after, output logic done_after,
                                output logic err_after, output logic drop_after);
        int k;
        start_j1 = 1'b0;
        norm_wr_valid = extra;
        for (k = 1; k <= 6000; k++) begin
            @(negedge clk);
            if (k == 1) start_j1 = norm_start;
            norm_wr_valid = (k <= beats);
            if (done || error) break;
        end
        j = k;
        got_done = done;
        got_err  = error;
        busy_at  = busy;
        norm_wr_valid = 1'b0;
        frame_ready = drop_done;
        @(negedge clk);
        frame_ready = 1'b0;
        busy_after = busy;
        done_after = done;
        err_after  = error;
        drop_after = frame_dropped;
    endtask

    initial begin
        int   lat;
        int   j;
        int   k;
        logic dropped;
        logic s1, gd, ge, ba, bb, da, ea, dr;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", 32'({scan_rd_valid, scan_rd_addr, norm_start, norm_min, norm_range,
                                  busy, done, error, frame_dropped}), 32'h0);
        chk("reset_range", 32'(norm_range), 32'h0);
        rst = 1'b0;

        // Ramp -100..667
        fill_ramp();
        run_scan(0, lat, dropped);
        chk("ramp_latency", 32'(lat), 32'(LAT_EXP));
        chk("ramp_min", 32'(norm_min), 32'h0000ff9c);
        chk("ramp_range", 32'(norm_range), 32'd767);
        chk("ramp_scan_len", 32'(nvalid), 32'd768);
        chk("ramp_scan_addr", 32'(addr_bad), 32'd0);
        finish_frame(768, 1'b0, 1'b0, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("ramp_start_pulse", 32'(s1), 32'd0);
        chk("ramp_done_time", 32'(j), 32'd769);
        chk("ramp_done", 32'({gd, ge, ba}), 32'b101);
        chk("ramp_after", 32'({bb, da, ea, dr}), 32'b0000);

        // Extremes at 5/700 with frame_ready dropped mid-scan and in DONE
        fill_const(16'h0000);
        mem[5]   = 16'h8000;
        mem[700] = 16'h7fff;
        run_scan(100, lat, dropped);
        chk("drop_scan", 32'(dropped), 32'd1);
        chk("ext_latency", 32'(lat), 32'(LAT_EXP));
        chk("ext_scan_addr", 32'({addr_bad, nvalid}), 32'({32'd0, 32'd768}));
        chk("ext_min", 32'(norm_min), 32'h00008000);
        chk("ext_range", 32'(norm_range), 32'h0000ffff);
        finish_frame(768, 1'b0, 1'b1, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("ext_done", 32'({gd, ge}), 32'b10);
        chk("drop_done", 32'(dr), 32'd1);
        chk("drop_done_idle", 32'({bb, da, scan_rd_valid}), 32'b000);

        // Min at addr 0, max at addr 767
        fill_const(16'h0000);
        mem[0]   = 16'hfffb;
        mem[767] = 16'h0009;
        run_scan(0, lat, dropped);
        chk("edge_min", 32'(norm_min), 32'h0000fffb);
        chk("edge_range", 32'(norm_range), 32'h0000000e);
        finish_frame(768, 1'b0, 1'b0, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("edge_done_time", 32'(j), 32'd769);

        // Constant 42, with a write strobe during START that must be ignored
        fill_const(16'd42);
        run_scan(0, lat, dropped);
        chk("const_min", 32'(norm_min), 32'd42);
        chk("const_range", 32'(norm_range), 32'd0);
        finish_frame(768, 1'b1, 1'b0, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("const_done_time", 32'(j), 32'd769);
        chk("const_done", 32'({gd, ge, bb}), 32'b100);

        // Only 767 beats -> timeout
        fill_ramp();
        run_scan(0, lat, dropped);
        chk("to_latency", 32'(lat), 32'(LAT_EXP));
        finish_frame(767, 1'b0, 1'b0, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("to_error_time", 32'(j), 32'd4097);
        chk("to_error", 32'({gd, ge, ba}), 32'b010);
        chk("to_after", 32'({bb, da, ea}), 32'b000);

        // Async reset at scan address 300, then a fresh full frame
        fill_const(16'h0000);
        mem[5] = 16'h8000;
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        k = 0;
        while (!(scan_rd_valid && scan_rd_addr == 10'd300) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_300", 32'(scan_rd_addr), 32'd300);
        rst = 1'b1;
        #1;
        chk("rst_abort_outputs", 32'({scan_rd_valid, scan_rd_addr, norm_start, busy, done,
                                      error, frame_dropped}), 32'h0);
        chk("rst_abort_min", 32'(norm_min), 32'h0);
        chk("rst_abort_range", 32'(norm_range), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", 32'({busy, done, error, scan_rd_valid}), 32'h0);
        fill_ramp();
        run_scan(0, lat, dropped);
        chk("rst_fresh_latency", 32'(lat), 32'(LAT_EXP));
        chk("rst_fresh_scan", 32'({addr_bad, nvalid}), 32'({32'd0, 32'd768}));
        chk("rst_fresh_min", 32'(norm_min), 32'h0000ff9c);
        chk("rst_fresh_range", 32'(norm_range), 32'd767);
        finish_frame(768, 1'b0, 1'b0, j, s1, gd, ge, ba, bb, da, ea, dr);
        chk("rst_fresh_done", 32'({gd, ge, bb}), 32'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
